// File: rtl/aes_decrypt_ctrl.sv
// Control FSM for the AES inverse cipher. It sequences the datapath register enables
// and drives the descending round counter out as the round-key index.
module aes_decrypt_ctrl #(
    parameter int NR = 10,
    parameter int KW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          decrypt,
    output logic          init,
    output logic          is_first,
    output logic          en_round_out,
    output logic          en_reg_row_out,
    output logic          en_reg_sub_out,
    output logic          en_reg_col_out,
    output logic          en_Dout,
    output logic [KW-1:0] key_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE, ARK0, ROW, SUB, ARK, COL, OUT, DONE
    } state_t;

    state_t        state_q;
    logic [KW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (decrypt) begin
                        state_q <= ARK0;
                        cnt_q   <= KW'(NR);
                    end
                end
                ARK0: begin
                    state_q <= ROW;
                    cnt_q   <= cnt_q - 1'b1;
                end
                ROW: state_q <= SUB;
                SUB: state_q <= ARK;
                // The key_idx=0 AddRoundKey is the last one, so COL never sees cnt=0
                ARK: state_q <= (cnt_q != '0) ? COL : OUT;
                COL: begin
                    state_q <= ROW;
                    cnt_q   <= cnt_q - 1'b1;
                end
                OUT:     state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        init           = 1'b0;
        is_first       = 1'b0;
        en_round_out   = 1'b0;
        en_reg_row_out = 1'b0;
        en_reg_sub_out = 1'b0;
        en_reg_col_out = 1'b0;
        en_Dout        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE: init = decrypt & ~reset;
            ARK0: begin
                en_round_out = 1'b1;
                is_first     = 1'b1;
                busy         = 1'b1;
            end
            ROW: begin
                en_reg_row_out = 1'b1;
                busy           = 1'b1;
            end
            SUB: begin
                en_reg_sub_out = 1'b1;
                busy           = 1'b1;
            end
            ARK: begin
                en_round_out = 1'b1;
                busy         = 1'b1;
            end
            COL: begin
                en_reg_col_out = 1'b1;
                busy           = 1'b1;
            end
            OUT: begin
                en_Dout = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                init = decrypt & ~reset;
            end
            default: ;
        endcase
    end

    assign key_idx = cnt_q;

endmodule

// File: doc/aes_decrypt_ctrl.md
Name: aes_decrypt_ctrl

Overview:
- Control FSM for the AES decryption datapath (inverse cipher); the counterpart of the encryption control unit.
- Sequences AddRoundKey(k[NR]), then NR-1 rounds of InvShiftRows -> InvSubBytes -> AddRoundKey(k[r]) -> InvMixColumns, then a final InvShiftRows -> InvSubBytes -> AddRoundKey(k[0]).
- Owns the descending round counter, drives it out as the round-key index, and produces one-hot datapath register enables plus the done/busy status.

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); must be >= 2
KW, 4, width of key_idx and of the internal round counter; must hold NR

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
decrypt  input  1  start request; sampled only in IDLE and DONE
init  output  1  load ciphertext into the state register; round counter loads NR next edge
is_first  output  1  high with the first AddRoundKey; selects loaded ciphertext as ARK input
en_round_out  output  1  capture AddRoundKey result register
en_reg_row_out  output  1  capture InvShiftRows result register
en_reg_sub_out  output  1  capture InvSubBytes result register
en_reg_col_out  output  1  capture InvMixColumns result register
en_Dout  output  1  capture plaintext output register
key_idx  output  KW  round-key index for the key store; equals the round counter
busy  output  1  high in every state except IDLE and DONE
done  output  1  plaintext valid; held until the next start

Behaviour:
- Reset (async): state <- IDLE, round counter <- 0. All outputs 0 during and after reset until decrypt is seen. Reset mid-operation aborts immediately, with no done and no en_Dout.
- Outputs decode combinationally from the state. init also depends on decrypt (Mealy). Every output not listed for a state is 0.
- States and transitions:
  - IDLE: if decrypt, init=1, cnt <= NR, next ARK0; else stay.
  - ARK0: en_round_out=1, is_first=1, busy=1; cnt <= cnt-1; next ROW.
  - ROW: en_reg_row_out=1; next SUB.
  - SUB: en_reg_sub_out=1; next ARK.
  - ARK: en_round_out=1; if cnt != 0, next COL; else next OUT.
  - COL: en_reg_col_out=1; cnt <= cnt-1; next ROW.
  - OUT: en_Dout=1; next DONE.
  - DONE: done=1; if decrypt, init=1, cnt <= NR, next ARK0 (back-to-back block with no IDLE cycle); else stay.
- key_idx = cnt at all times, so the key for each AddRoundKey step is presented during that state:
  - NR in ARK0;
  - NR-1..1 in successive ARK states;
  - 0 in the final ARK.
- Counter rules:
  - Decrements only in ARK0 and COL.
  - Never wraps: COL is unreachable with cnt=0.
  - Holds in all other states.
- Latency: the init cycle is T0, and done first goes high at T0 + 4*NR + 2 (T0+42 for NR=10).
- Pulse counts per block:
  - en_round_out: NR+1
  - en_reg_row_out: NR
  - en_reg_sub_out: NR
  - en_reg_col_out: NR-1
  - en_Dout: 1
  - init: 1
- The enables are mutually exclusive (at most one en_* high per cycle).
- decrypt is ignored while busy=1, and a held decrypt does not restart mid-block. A held decrypt in DONE restarts every 4*NR+2 cycles, with done high for one cycle each time.
- Unused state encodings go to IDLE on the next edge with all outputs 0.

Test Plan:
- Reset, then decrypt=1 for 1 cycle (NR=10) -> init at T0, is_first+en_round_out with key_idx=10 at T1, first en_reg_row_out at T2, en_Dout at T41, done=1 from T42 and held.
- Count enables over one block -> 11 en_round_out (key_idx 10,9,...,1,0 in order), 10 row, 10 sub, 9 col; no cycle with two en_* high; no en_reg_col_out after the key_idx=0 ARK.
- decrypt held high continuously -> DONE at T42 asserts init the same cycle, ARK0 at T43, done pulses every 42 cycles, busy low only in DONE cycles.
- decrypt toggled during busy (e.g. at T10, T20) -> no effect on sequence or counter; done still at T42.
- reset asserted at T25 mid-round -> outputs 0 asynchronously, state IDLE, key_idx=0; en_Dout/done never asserted; new decrypt restarts with full 42-cycle latency.
- Elaborate with NR=14, KW=4 -> key_idx starts at 14, done at T0+58, 15 en_round_out and 13 en_reg_col_out pulses.
